// File: rtl/srlzr_pkg.sv
// Shared serializer/deserializer link definitions.
// State codes, default width and even-parity helper.
package srlzr_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam int DEFAULT_DATA_WIDTH = 8;

  // Even parity: bit that makes the total count of ones even.
  function automatic logic even_par(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/srlzr_out_reg.sv
// One-entry valid/ready holding register with load/drop/overrun.
// Ports: clk, rst (sync, active-low), i_load, i_data, i_ready,
//        o_data, o_valid, o_overrun (sticky).
module srlzr_out_reg
  import srlzr_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_overrun
);

  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_ovr;
  logic                  w_free;

  // Slot is usable if empty or draining this cycle.
  assign w_free = !r_valid || i_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (i_load) begin
      if (w_free) begin
        r_data  <= i_data;
        r_valid <= 1'b1;
      end else begin
        r_ovr <= 1'b1;
      end
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_overrun = r_ovr;

endmodule

// File: rtl/dsrlzr_sipo.sv
// LSB-first SIPO deserializer with sync-marker word alignment.
// Ports: clk, rst (sync, active-low), iSRL_IN, iSHIFT, iSYNC, iREADY,
//        oDATA_OUT, oVALID, oOVERRUN; oPAR_ERR with DSRLZR_PARITY_EN.
module dsrlzr_sipo
  import srlzr_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iSRL_IN,
  input  logic                  iSHIFT,
  input  logic                  iSYNC,
  input  logic                  iREADY,
  output logic [DATA_WIDTH-1:0] oDATA_OUT,
  output logic                  oVALID,
`ifdef DSRLZR_PARITY_EN
  output logic                  oPAR_ERR,
`endif
  output logic                  oOVERRUN
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
`ifdef DSRLZR_PARITY_EN
  localparam int FRAME = DATA_WIDTH + 1;
`else
  localparam int FRAME = DATA_WIDTH;
`endif
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_sr;
  logic [DATA_WIDTH-1:0] w_sr_nxt;
  logic [DATA_WIDTH-1:0] w_shift;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_start;
  logic                  w_load;
  logic                  w_perr;

  assign w_start = iSHIFT && iSYNC;
  assign w_shift = {iSRL_IN, r_sr[DATA_WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst) r_state <= HUNT;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_start) w_state_nxt = RECV;
  end

  // Sync has priority everywhere: it restarts the word even mid-frame.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_sr_nxt  = r_sr;
    w_word    = w_shift;
    w_load    = 1'b0;
    w_perr    = 1'b0;
    if (w_start) begin
      w_sr_nxt  = {iSRL_IN, {(DATA_WIDTH-1){1'b0}}};
      w_cnt_nxt = CNT_W'(1);
    end else if (iSHIFT && r_state == RECV) begin
      if (r_cnt == LAST) begin
        w_cnt_nxt = '0;
`ifdef DSRLZR_PARITY_EN
        // Current bit is parity; data is already fully in r_sr.
        w_word = r_sr;
        if (iSRL_IN == even_par(64'(r_sr))) w_load = 1'b1;
        else                                w_perr = 1'b1;
`else
        w_sr_nxt = w_shift;
        w_load   = 1'b1;
`endif
      end else begin
        w_sr_nxt  = w_shift;
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
      r_sr  <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_sr  <= w_sr_nxt;
    end
  end

`ifdef DSRLZR_PARITY_EN
  logic r_perr;

  always_ff @(posedge clk) begin
    if (!rst) r_perr <= 1'b0;
    else      r_perr <= w_perr;
  end

  assign oPAR_ERR = r_perr;
`else
  logic w_perr_unused;
  assign w_perr_unused = w_perr;
`endif

  srlzr_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_data   (w_word),
    .i_ready  (iREADY),
    .o_data   (oDATA_OUT),
    .o_valid  (oVALID),
    .o_overrun(oOVERRUN)
  );

endmodule

// File: tb/tb_dsrlzr_sipo.sv
// Directed self-checking bench for dsrlzr_sipo.
// Frames carry a parity bit when DSRLZR_PARITY_EN is defined.
module tb_dsrlzr_sipo;

`ifdef DSRLZR_PARITY_EN
  localparam int FLEN = 9;
`else
  localparam int FLEN = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       srl = 1'b0;
  logic       shf = 1'b0;
  logic       syn = 1'b0;
  logic       rdy = 1'b0;
  logic [7:0] dout;
  logic       vld;
  logic       ovr;
`ifdef DSRLZR_PARITY_EN
  logic       perr;
`endif

  int runs  = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dsrlzr_sipo #(.DATA_WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .iSRL_IN  (srl),
    .iSHIFT   (shf),
    .iSYNC    (syn),
    .iREADY   (rdy),
    .oDATA_OUT(dout),
    .oVALID   (vld),
`ifdef DSRLZR_PARITY_EN
    .oPAR_ERR (perr),
`endif
    .oOVERRUN (ovr)
  );

  function automatic logic fbit(input logic [7:0] d, input int i);
    if (i < 8) return d[i];
    return ^d;
  endfunction

  task automatic shift(input logic b, input logic s);
    srl = b;
    syn = s;
    shf = 1'b1;
    @(posedge clk);
    #1;
    shf = 1'b0;
    syn = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic s);
    for (int i = 0; i < FLEN; i++) shift(fbit(d, i), s && i == 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    idle();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rdy = 1'b1;
    do_reset();
    runs++;
    if (vld !== 1'b0) begin
      fails++;
      $display("FAIL reset_valid got=%b exp=0", vld);
    end
    runs++;
    if (dout !== 8'h00) begin
      fails++;
      $display("FAIL reset_data got=%h exp=00", dout);
    end
    runs++;
    if (ovr !== 1'b0) begin
      fails++;
      $display("FAIL reset_overrun got=%b exp=0", ovr);
    end
  endtask

  task automatic test_hunt();
    logic seen;
    logic [7:0] a5;
    a5 = 8'hA5;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      shift(1'b1, 1'b0);
      if (vld !== 1'b0) seen = 1'b1;
    end
    for (int i = 0; i < FLEN - 1; i++) begin
      shift(fbit(a5, i), i == 0);
      if (vld !== 1'b0) seen = 1'b1;
    end
    runs++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL hunt_early_valid got=%b exp=0", seen);
    end
    shift(fbit(a5, FLEN - 1), 1'b0);
    runs++;
    if (vld !== 1'b1 || dout !== 8'hA5) begin
      fails++;
      $display("FAIL hunt_word got=%b/%h exp=1/a5", vld, dout);
    end
    idle();
    runs++;
    if (vld !== 1'b0) begin
      fails++;
      $display("FAIL hunt_consume got=%b exp=0", vld);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ff;
    ff = 8'hFF;
    rdy = 1'b1;
    send_frame(8'h3C, 1'b1);
    runs++;
    if (vld !== 1'b1 || dout !== 8'h3C) begin
      fails++;
      $display("FAIL b2b_first got=%b/%h exp=1/3c", vld, dout);
    end
    shift(fbit(ff, 0), 1'b0);
    runs++;
    if (vld !== 1'b0) begin
      fails++;
      $display("FAIL b2b_pulse got=%b exp=0", vld);
    end
    for (int i = 1; i < FLEN; i++) shift(fbit(ff, i), 1'b0);
    runs++;
    if (vld !== 1'b1 || dout !== 8'hFF || ovr !== 1'b0) begin
      fails++;
      $display("FAIL b2b_second got=%b/%h/%b exp=1/ff/0",
               vld, dout, ovr);
    end
    idle();
  endtask

  task automatic test_overrun();
    rdy = 1'b0;
    send_frame(8'h12, 1'b1);
    runs++;
    if (vld !== 1'b1 || dout !== 8'h12 || ovr !== 1'b0) begin
      fails++;
      $display("FAIL ovr_first got=%b/%h/%b exp=1/12/0", vld, dout, ovr);
    end
    send_frame(8'h34, 1'b0);
    runs++;
    if (vld !== 1'b1 || dout !== 8'h12 || ovr !== 1'b1) begin
      fails++;
      $display("FAIL ovr_hold got=%b/%h/%b exp=1/12/1", vld, dout, ovr);
    end
    rdy = 1'b1;
    idle();
    idle();
    runs++;
    if (vld !== 1'b0 || dout !== 8'h12 || ovr !== 1'b1) begin
      fails++;
      $display("FAIL ovr_drain got=%b/%h/%b exp=0/12/1", vld, dout, ovr);
    end
  endtask

  task automatic test_resync();
    logic seen;
    logic [7:0] w;
    w = 8'h5A;
    seen = 1'b0;
    rdy = 1'b1;
    do_reset();
    shift(1'b1, 1'b1);
    shift(1'b1, 1'b0);
    shift(1'b1, 1'b0);
    for (int i = 0; i < FLEN - 1; i++) begin
      shift(fbit(w, i), i == 0);
      if (vld !== 1'b0) seen = 1'b1;
    end
    runs++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL resync_stale got=%b exp=0", seen);
    end
    shift(fbit(w, FLEN - 1), 1'b0);
    runs++;
    if (vld !== 1'b1 || dout !== 8'h5A) begin
      fails++;
      $display("FAIL resync_word got=%b/%h exp=1/5a", vld, dout);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    rdy = 1'b0;
    send_frame(8'hC3, 1'b1);
    runs++;
    if (vld !== 1'b1 || dout !== 8'hC3) begin
      fails++;
      $display("FAIL rmid_pre got=%b/%h exp=1/c3", vld, dout);
    end
    for (int i = 0; i < 4; i++) shift(1'b1, 1'b0);
    rst = 1'b0;
    idle();
    runs++;
    if (vld !== 1'b0 || dout !== 8'h00 || ovr !== 1'b0) begin
      fails++;
      $display("FAIL rmid_clear got=%b/%h/%b exp=0/00/0", vld, dout, ovr);
    end
    rst = 1'b1;
    rdy = 1'b1;
    send_frame(8'h81, 1'b1);
    runs++;
    if (vld !== 1'b1 || dout !== 8'h81) begin
      fails++;
      $display("FAIL rmid_after got=%b/%h exp=1/81", vld, dout);
    end
    idle();
  endtask

`ifdef DSRLZR_PARITY_EN
  task automatic test_parity();
    logic [7:0] a5;
    a5 = 8'hA5;
    rdy = 1'b1;
    for (int i = 0; i < 8; i++) shift(a5[i], i == 0);
    shift(1'b0, 1'b0);
    runs++;
    if (vld !== 1'b1 || dout !== 8'hA5 || perr !== 1'b0) begin
      fails++;
      $display("FAIL par_good got=%b/%h/%b exp=1/a5/0", vld, dout, perr);
    end
    idle();
    for (int i = 0; i < 8; i++) shift(a5[i], i == 0);
    shift(1'b1, 1'b0);
    runs++;
    if (vld !== 1'b0 || perr !== 1'b1) begin
      fails++;
      $display("FAIL par_bad got=%b/%b exp=0/1", vld, perr);
    end
    idle();
    runs++;
    if (vld !== 1'b0 || perr !== 1'b0) begin
      fails++;
      $display("FAIL par_pulse got=%b/%b exp=0/0", vld, perr);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_hunt();
    test_back_to_back();
    test_overrun();
    test_resync();
    test_reset_mid();
`ifdef DSRLZR_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", runs, fails);
    $finish;
  end

endmodule

// File: doc/dsrlzr_sipo.md
Name: dsrlzr_sipo

Overview:
- Serial-input / parallel-output (SIPO) deserializer: the receive end of the team's PISO serializer link.
- Collects LSB-first bits, strobed by iSHIFT, into DATA_WIDTH-bit words and aligns them to a start marker (iSYNC).
- Presents each completed word on a one-entry valid/ready output register toward the parallel consumer.
- Sits between the serial line/transceiver front end and the parallel data path.

Parameters:
- DATA_WIDTH, 8, word width in bits; must be >= 2.
- CNT_W, $clog2(DATA_WIDTH+1), bit-counter width; derived localparam, not overridable.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset (0 = reset), sampled on posedge clk.
- iSRL_IN  in  1  serial data bit.
- iSHIFT  in  1  bit strobe; iSRL_IN is sampled only on cycles with iSHIFT=1.
- iSYNC  in  1  qualified by iSHIFT; marks the current bit as bit 0 of a new word.
- iREADY  in  1  consumer accepts oDATA_OUT.
- oDATA_OUT  out  DATA_WIDTH  assembled word; bit 0 is the first bit received.
- oVALID  out  1  oDATA_OUT holds an unconsumed word.
- oOVERRUN  out  1  sticky flag: a completed word was dropped because the output register was full.

Behaviour:
- Reset (rst=0 at posedge): state=HUNT, cnt=0, shift reg=0, oDATA_OUT=0, oVALID=0, oOVERRUN=0 (and oPAR_ERR=0 if the optional feature is built). A partial word in flight at reset is discarded.
- States:
  - HUNT: iSHIFT without iSYNC is ignored. iSHIFT&iSYNC captures iSRL_IN as bit 0, sets cnt=1, goes to RECV.
  - RECV: each iSHIFT shifts right: sr <= {iSRL_IN, sr[DATA_WIDTH-1:1]}, and cnt increments.
    - iSHIFT&iSYNC mid-word (cnt != 0): resync. Partial word discarded, current bit taken as bit 0, cnt=1, no error flag.
    - iSHIFT with cnt==DATA_WIDTH-1: word complete. Full word = {iSRL_IN, sr[DATA_WIDTH-1:1]}. Sets cnt=0 and stays in RECV, so the next word follows back-to-back without a new iSYNC.
    - iSYNC on the bit after a completed word: accepted as a normal word start.
- Latency: oVALID=1 and oDATA_OUT updated on the same clock edge that samples the last bit.
- Output handshake:
  - Transfer occurs on any cycle with oVALID&iREADY.
  - While oVALID&!iREADY, oDATA_OUT stays stable.
  - oVALID&iREADY with no new word: oVALID <= 0 next edge; oDATA_OUT keeps its last value.
  - Word completes while oVALID=0, or while oVALID&iREADY in the same cycle: word loaded, oVALID=1 (back-to-back, no bubble).
  - Word completes while oVALID&!iREADY: new word dropped, held word untouched, oOVERRUN <= 1 until reset.
- iSYNC without iSHIFT has no effect. iSHIFT may be asserted every cycle.

Optional Feature:
- Macro: DSRLZR_PARITY_EN.
- Defined:
  - Each frame is DATA_WIDTH data bits plus one even-parity bit; cnt counts to DATA_WIDTH.
  - Word completes on the parity bit. A mismatch drops the word (no oVALID, no overrun check) and pulses oPAR_ERR for one cycle.
  - Adds port oPAR_ERR, out, 1, reset 0.
  - The peer serializer must be built with matching parity.
- Undefined: no parity bit and no oPAR_ERR port; frame is exactly DATA_WIDTH bits.

Decomposition:
- Package srlzr_pkg holds:
  - HUNT/RECV state encodings (1 bit);
  - DEFAULT_DATA_WIDTH=8;
  - even-parity function, shared with the serializer.
- Sub-module srlzr_out_reg: one-entry valid/ready holding register with load/drop/overrun logic, parameterised by DATA_WIDTH.

Test Plan:
- Reset then HUNT filter: 5 iSHIFT pulses with iSYNC=0 -> oVALID stays 0. Then iSYNC+iSHIFT and bits 1,0,1,0,0,1,0,1 -> oDATA_OUT=8'hA5, oVALID=1 on the 8th strobe edge.
- Back-to-back words: 8'h3C then 8'hFF on 16 consecutive iSHIFT cycles, iREADY=1 -> two single-cycle oVALID pulses with no bubble, data 3C then FF, oOVERRUN=0.
- Backpressure/overrun: iREADY=0, send 8'h12 then 8'h34 -> oDATA_OUT holds 12, oOVERRUN=1. Raise iREADY -> 12 accepted, oVALID=0, 34 never appears.
- Resync: iSYNC after 3 bits of a word, then full 8'h5A -> only 5A is output.
- Reset mid-word: rst=0 after 4 bits -> all outputs 0. Next synced 8'h81 is received correctly.
- DSRLZR_PARITY_EN: 8'hA5 with parity 0 -> output A5. 8'hA5 with parity 1 -> no oVALID, oPAR_ERR pulses for exactly one cycle.
